// File: rtl/led_seq_if.sv
// led_seq_if: display-update request handshake between a requester and led_seq_ctrl
interface led_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_value;
    logic [3:0]  req_dp;
    logic        req_blank;
    modport master (output req_valid, req_value, req_dp, req_blank, input req_ready);
    modport slave  (input req_valid, req_value, req_dp, req_blank, output req_ready);
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: writes a 4-digit hex value as 7-segment bytes onto a display bus shared with a CPU store port
module led_seq_ctrl #(
    parameter logic [7:0] BASE_ADDR      = 8'hF0,
    parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    led_seq_if.slave   req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data,
    output logic       out_we,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done
);
    typedef enum logic {IDLE, WRITE} state_t;
    localparam logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx, msd;
    logic [15:0] val;
    logic [3:0]  dp, nib;
    logic        blank, ctrl_wr, accept;
    logic [7:0]  seg_raw, seg;
    always_comb begin
        msd      = val[15:12] != 4'd0 ? 2'd3 : val[11:8] != 4'd0 ? 2'd2 : val[7:4] != 4'd0 ? 2'd1 : 2'd0;
        nib      = 4'(val >> {idx, 2'b00});
        // digits above the most significant nonzero nibble go dark; digit 0 never does since msd >= 0
        seg_raw  = {dp[idx], (blank && idx > msd) ? 7'h00 : HEX[nib][6:0]};
        seg      = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        accept   = state == IDLE && req.req_valid;
        ctrl_wr  = state == WRITE && !cpu_we;
        state_nx = accept ? WRITE : (ctrl_wr && idx == 2'd3) ? IDLE : state;
        idx_nx   = state == IDLE ? 2'd0 : ctrl_wr ? idx + 2'd1 : idx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            val      <= 16'h0;
            dp       <= 4'h0;
            blank    <= 1'b0;
            out_we   <= 1'b0;
            out_addr <= 8'h00;
            out_data <= 8'h00;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            val      <= accept ? req.req_value : val;
            dp       <= accept ? req.req_dp : dp;
            blank    <= accept ? req.req_blank : blank;
            out_we   <= cpu_we | ctrl_wr;
            out_addr <= cpu_we ? cpu_addr : ctrl_wr ? BASE_ADDR + 8'(idx) : 8'h00;
            out_data <= cpu_we ? cpu_data : ctrl_wr ? seg : 8'h00;
            done     <= ctrl_wr && idx == 2'd3;
        end
    end
    assign req.req_ready = state == IDLE;
    assign busy          = state == WRITE;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: randomized and directed scoreboard bench for led_seq_ctrl
module tb_led_seq_ctrl;
    typedef struct packed {logic [7:0] a; logic [7:0] d; logic last;} wr_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    led_seq_if req();
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_data = 8'h00;
    logic       out_we, busy, done;
    logic [7:0] out_addr, out_data;
    led_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .req(req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
                      .cpu_data(cpu_data), .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
                      .busy(busy), .done(done));
    logic [7:0] hex_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    wr_t        ctrl_q[$], cpu_q[$], e;
    logic [7:0] obs_q[$];
    int         acc_q[$];
    int         vectors = 0, errors = 0, cycle = 0, ctrl_writes = 0;
    logic       rst_e = 1'b0, cpu_e = 1'b0, due_e = 1'b0;
    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", n, act, exp, cycle);
        end
    endfunction
    // digit i shows blank when blanking is on and nothing nonzero sits at or above it
    function automatic logic [7:0] seg_model(logic [15:0] v, logic [3:0] dp, logic blk, int i);
        logic [15:0] upper;
        logic [7:0]  s;
        upper = v >> (4 * i);
        s = (blk && i > 0 && upper == 16'h0) ? 8'h00 : hex_tbl[upper[3:0]];
        s[7] = dp[i];
        return ~s;
    endfunction
    always @(posedge clk) begin
        rst_e <= !rst_n;
        cpu_e <= rst_n && cpu_we;
        due_e <= rst_n && ctrl_q.size() != 0;
        cycle <= cycle + 1;
        if (rst_n && cpu_we) cpu_q.push_back({cpu_addr, cpu_data, 1'b0});
        if (rst_n && req.req_valid && ctrl_q.size() == 0) begin
            for (int i = 0; i < 4; i++)
                ctrl_q.push_back({8'hF0 + 8'(i), seg_model(req.req_value, req.req_dp, req.req_blank, i), i == 3});
            acc_q.push_back(cycle);
        end
    end
    always @(negedge clk) begin
        if (rst_e) begin
            ctrl_q.delete();
            chk("rst_we", out_we, 0);
            chk("rst_addr", out_addr, 0);
            chk("rst_data", out_data, 0);
            chk("rst_done", done, 0);
        end else if (cpu_e) begin
            e = cpu_q.pop_front();
            chk("cpu_we", out_we, 1);
            chk("cpu_addr", out_addr, e.a);
            chk("cpu_data", out_data, e.d);
            chk("cpu_done", done, 0);
        end else if (due_e) begin
            e = ctrl_q.pop_front();
            obs_q.push_back(out_data);
            ctrl_writes++;
            chk("dig_we", out_we, 1);
            chk("dig_addr", out_addr, e.a);
            chk("dig_data", out_data, e.d);
            chk("dig_done", done, e.last);
        end else begin
            chk("idle_we", out_we, 0);
            chk("idle_addr", out_addr, 0);
            chk("idle_data", out_data, 0);
            chk("idle_done", done, 0);
        end
        chk("ready", req.req_ready, ctrl_q.size() == 0);
        chk("busy", busy, ctrl_q.size() != 0);
    end
    task automatic send(input logic [15:0] v, input logic [3:0] dp, input logic b);
        int n = acc_q.size();
        req.req_valid = 1'b1;
        req.req_value = v;
        req.req_dp = dp;
        req.req_blank = b;
        for (int k = 0; k < 20 && acc_q.size() == n; k++) @(negedge clk);
        req.req_valid = 1'b0;
        chk("accept_timeout", acc_q.size(), n + 1);
    endtask
    task automatic wait_idle();
        for (int k = 0; k < 60 && ctrl_q.size() != 0; k++) @(negedge clk);
        chk("idle_timeout", ctrl_q.size(), 0);
        @(negedge clk);
    endtask
    task automatic expect4(string n, input logic [7:0] a, b, c, d);
        chk({n, "_cnt"}, obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            chk({n, "_0"}, obs_q[0], a);
            chk({n, "_1"}, obs_q[1], b);
            chk({n, "_2"}, obs_q[2], c);
            chk({n, "_3"}, obs_q[3], d);
        end
        obs_q.delete();
    endtask
    initial begin
        req.req_valid = 1'b0;
        req.req_value = 16'h0;
        req.req_dp = 4'h0;
        req.req_blank = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs_q.delete();
        send(16'h1234, 4'b0000, 1'b0);
        wait_idle();
        expect4("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        send(16'h0070, 4'b0001, 1'b1);
        wait_idle();
        expect4("v0070", 8'h40, 8'hF8, 8'hFF, 8'hFF);
        send(16'h0000, 4'b0000, 1'b1);
        wait_idle();
        expect4("v0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        // CPU store lands in the cycle that would have written F1
        send(16'h1234, 4'b0000, 1'b0);
        @(negedge clk);
        cpu_we = 1'b1;
        cpu_addr = 8'hF2;
        cpu_data = 8'h5A;
        @(negedge clk);
        cpu_we = 1'b0;
        wait_idle();
        expect4("stall", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        send(16'h1234, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_cnt", obs_q.size(), 2);
        obs_q.delete();
        acc_q.delete();
        ctrl_writes = 0;
        req.req_valid = 1'b1;
        req.req_value = 16'hBEEF;
        req.req_blank = 1'b0;
        for (int k = 0; k < 20 && acc_q.size() < 1; k++) @(negedge clk);
        req.req_value = 16'h00A5;
        req.req_blank = 1'b1;
        for (int k = 0; k < 20 && acc_q.size() < 2; k++) @(negedge clk);
        req.req_valid = 1'b0;
        wait_idle();
        chk("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() == 2) chk("b2b_gap", acc_q[1] - acc_q[0], 5);
        chk("b2b_writes", ctrl_writes, 8);
        obs_q.delete();
        for (int k = 0; k < 800; k++) begin
            rst_n = ($urandom % 60) != 0;
            req.req_valid = ($urandom % 3) == 0;
            req.req_value = 16'($urandom) & (16'hFFFF >> (4 * ($urandom % 4)));
            req.req_dp = 4'($urandom);
            req.req_blank = 1'($urandom);
            cpu_we = ($urandom % 5) == 0;
            cpu_addr = ($urandom % 2) ? 8'hF0 + 8'($urandom % 4) : 8'($urandom);
            cpu_data = 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        req.req_valid = 1'b0;
        cpu_we = 1'b0;
        wait_idle();
        chk("cpu_q_empty", cpu_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
